// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccff_loader_pkg                                                  |
// | Shared FSM encoding and sizing helper for the bitstream loader.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of bitstream words needed to fill a chain of len bits.
  function automatic int words_for(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccff_word_serializer                                             |
// | MSB-first word serializer driving the registered chain inputs.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [CNT_W-1:0]  count,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              word_last
);

  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_cnt;

  // The bit on ccff_head right now is the final one of this word.
  assign word_last = ccff_shift_en && (r_cnt == CNT_W'(1));

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_sreg        <= '0;
      r_cnt         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else if (clear) begin
      r_cnt         <= '0;
      ccff_shift_en <= 1'b0;
    end else if (load) begin
      // MSB goes straight to the output so it is presented the cycle after the handshake
      ccff_head     <= data[WORD_W-1];
      r_sreg        <= data << 1;
      r_cnt         <= count;
      ccff_shift_en <= 1'b1;
    end else if (ccff_shift_en) begin
      if (r_cnt == CNT_W'(1)) begin
        ccff_shift_en <= 1'b0;
      end else begin
        ccff_head <= r_sreg[WORD_W-1];
        r_sreg    <= r_sreg << 1;
      end
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccff_bitstream_loader                                            |
// | Streams bitstream words into the config chain, tracks readback.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter  int WORD_W    = 8,
  parameter  int CHAIN_LEN = 30,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              tail_parity
);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_word_last;
  logic             w_idle_or_done;
  logic [CNT_W-1:0] w_remaining;
  logic [CNT_W-1:0] w_word_cnt;

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_remaining    = CNT_W'(CHAIN_LEN) - bit_count;
  // Final word may be partial: only the bits still missing from the chain are shifted.
  assign w_word_cnt     = (int'(w_remaining) > WORD_W) ? CNT_W'(WORD_W) : w_remaining;

  // Gated by abort/reset so a word is never accepted in a cycle that discards it.
  assign bs_ready = (r_state == LOAD) && pReset && !abort;
  assign busy     = (r_state == LOAD) || (r_state == SHIFT);
  assign done     = (r_state == DONE);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) w_next = LOAD;
      LOAD: begin
        w_load = bs_valid && bs_ready;
        if (w_load) w_next = SHIFT;
      end
      SHIFT: begin
        if (w_word_last)
          w_next = ((int'(bit_count) + 1) == CHAIN_LEN) ? DONE : LOAD;
      end
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_state     <= IDLE;
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else begin
      r_state <= w_next;
      if (abort) begin
        bit_count   <= bit_count;
        tail_parity <= tail_parity;
      end else if (w_idle_or_done && start) begin
        bit_count   <= '0;
        tail_parity <= 1'b0;
      end else if (ccff_shift_en) begin
        bit_count   <= bit_count + CNT_W'(1);
        tail_parity <= tail_parity ^ ccff_tail;
      end
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .clear         (abort),
    .load          (w_load),
    .data          (bs_data),
    .count         (w_word_cnt),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .word_last     (w_word_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ccff_bitstream_loader                                         |
// | Directed vector bench with a behavioural chain model.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 30;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_count;
  logic              tail_parity;

  int n_checks = 0;
  int n_fail   = 0;

  // Chain model: bit CHAIN_LEN-1 is the flop nearest ccff_tail.
  logic [CHAIN_LEN-1:0] chain       = '0;
  logic                 preload_req = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  int hs_cnt   = 0;
  int busy_cnt = 0;
  int sh_cnt   = 0;

  assign ccff_tail = chain[CHAIN_LEN-1];

  ccff_bitstream_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .bs_data       (bs_data),
    .bs_valid      (bs_valid),
    .bs_ready      (bs_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count),
    .tail_parity   (tail_parity)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (bs_valid && bs_ready) hs_cnt <= hs_cnt + 1;
    if (busy)                 busy_cnt <= busy_cnt + 1;
    if (ccff_shift_en)        sh_cnt <= sh_cnt + 1;
    if (preload_req)          chain <= preload_val;
    else if (ccff_shift_en)   chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  typedef struct {
    logic [31:0]          words;
    int                   stall;
    logic [CHAIN_LEN-1:0] preload;
    logic [CHAIN_LEN-1:0] exp_chain;
    logic                 exp_parity;
    int                   exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] words, input int hs0, inout int stall_left);
    int idx;
    idx = hs_cnt - hs0;
    if (idx == 1 && stall_left > 0 && bs_ready) begin
      bs_valid   = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      bs_valid = 1'b1;
      if (idx < 4) bs_data = words[31 - 8*idx -: 8];
      else         bs_data = 8'h00;
    end
  endtask

  task automatic begin_load(input logic [CHAIN_LEN-1:0] pre, output int hs0, output int b0, output int s0);
    bs_valid    = 1'b0;
    preload_val = pre;
    preload_req = 1'b1;
    @(negedge prog_clk);
    preload_req = 1'b0;
    hs0 = hs_cnt;
    b0  = busy_cnt;
    s0  = sh_cnt;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  // Feed words until done (stop_at < 0) or until bit_count reaches stop_at.
  task automatic feed(input logic [31:0] words, input int hs0, input int stall, input int stop_at);
    int  stall_left;
    bit  reached;
    stall_left = stall;
    reached    = 1'b0;
    for (int c = 0; c < 400 && !reached; c++) begin
      if (stop_at < 0) reached = (done == 1'b1);
      else             reached = (int'(bit_count) == stop_at);
      if (!reached) begin
        drive(words, hs0, stall_left);
        @(negedge prog_clk);
      end
    end
    check("feed_timeout", {63'd0, reached}, 64'd1);
  endtask

  task automatic finish_checks(input vec_t v, input int hs0, input int b0, input int s0);
    int dummy;
    dummy = 0;
    // Keep offering words after completion; none may be accepted.
    repeat (3) begin
      drive(v.words, hs0, dummy);
      @(negedge prog_clk);
    end
    bs_valid = 1'b0;
    check("done",        {63'd0, done}, 64'd1);
    check("bit_count",   64'(bit_count), 64'(CHAIN_LEN));
    check("tail_parity", {63'd0, tail_parity}, {63'd0, v.exp_parity});
    check("chain",       64'(chain), 64'(v.exp_chain));
    check("handshakes",  64'(hs_cnt - hs0), 64'(words_for(CHAIN_LEN, WORD_W)));
    check("shift_en_cycles", 64'(sh_cnt - s0), 64'(CHAIN_LEN));
    check("busy_cycles", 64'(busy_cnt - b0), 64'(v.exp_busy));
    check("bs_ready_after", {63'd0, bs_ready}, 64'd0);
  endtask

  task automatic check_idle_after_abort(input string tag, input int exp_bc);
    check({tag, "_shift_en"},  {63'd0, ccff_shift_en}, 64'd0);
    check({tag, "_busy"},      {63'd0, busy}, 64'd0);
    check({tag, "_done"},      {63'd0, done}, 64'd0);
    check({tag, "_bs_ready"},  {63'd0, bs_ready}, 64'd0);
    check({tag, "_bit_count"}, 64'(bit_count), 64'(exp_bc));
  endtask

  initial begin
    int hs0, b0, s0;

    vecs[0] = '{32'hA53CFFC0, 0, 30'h0,        30'h294F3FF0, 1'b0, 34};
    vecs[1] = '{32'hA53CFFFF, 0, 30'h0,        30'h294F3FFF, 1'b0, 34};
    vecs[2] = '{32'hA53CFFC0, 5, 30'h0,        30'h294F3FF0, 1'b0, 39};
    vecs[3] = '{32'hA53CFFC0, 0, 30'h1,        30'h294F3FF0, 1'b1, 34};
    vecs[4] = '{32'hA53CFFC0, 0, 30'h3,        30'h294F3FF0, 1'b0, 34};

    pReset   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    bs_valid = 1'b1;
    bs_data  = 8'hA5;
    repeat (3) @(negedge prog_clk);
    check("rst_bs_ready",    {63'd0, bs_ready}, 64'd0);
    check("rst_head",        {63'd0, ccff_head}, 64'd0);
    check("rst_shift_en",    {63'd0, ccff_shift_en}, 64'd0);
    check("rst_busy",        {63'd0, busy}, 64'd0);
    check("rst_done",        {63'd0, done}, 64'd0);
    check("rst_bit_count",   64'(bit_count), 64'd0);
    check("rst_tail_parity", {63'd0, tail_parity}, 64'd0);
    check("rst_handshakes",  64'(hs_cnt), 64'd0);
    pReset   = 1'b1;
    bs_valid = 1'b0;
    @(negedge prog_clk);

    for (int i = 0; i < 5; i++) begin
      begin_load(vecs[i].preload, hs0, b0, s0);
      feed(vecs[i].words, hs0, vecs[i].stall, -1);
      finish_checks(vecs[i], hs0, b0, s0);
    end

    // Abort mid-shift, then start+abort together, then a clean reload.
    begin_load(30'h0, hs0, b0, s0);
    feed(vecs[0].words, hs0, 0, 12);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check_idle_after_abort("abort", 12);
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {63'd0, busy}, 64'd0);
    begin_load(30'h0, hs0, b0, s0);
    feed(vecs[0].words, hs0, 0, -1);
    finish_checks(vecs[0], hs0, b0, s0);

    // Reset mid-shift abandons the load and clears the counters.
    begin_load(30'h0, hs0, b0, s0);
    feed(vecs[0].words, hs0, 0, 12);
    pReset = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b1;
    check_idle_after_abort("reset_mid", 0);
    check("reset_mid_head", {63'd0, ccff_head}, 64'd0);
    begin_load(30'h0, hs0, b0, s0);
    feed(vecs[0].words, hs0, 0, -1);
    finish_checks(vecs[0], hs0, b0, s0);

    // Start while busy must not restart the load.
    begin_load(30'h0, hs0, b0, s0);
    feed(vecs[0].words, hs0, 0, 12);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check("busy_start_bit_count", 64'(bit_count), 64'd13);
    check("busy_start_busy",      {63'd0, busy}, 64'd1);
    feed(vecs[0].words, hs0, 0, -1);
    finish_checks(vecs[0], hs0, b0, s0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
